prog_counter: RTL and testbench

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/counter_pkg.sv | 15 +
 rtl/tick_gen.sv | 33 +++
 rtl/prog_counter.sv | 85 ++++++++
 tb/tb_prog_counter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the programmable counter: mode encodings and a
// prescaler width helper.
package counter_pkg;

    // Mode encodings; the spare code 2'b11 behaves as WRAP.
    localparam logic [1:0] WRAP    = 2'b00;
    localparam logic [1:0] SAT     = 2'b01;
    localparam logic [1:0] ONESHOT = 2'b10;

    // Prescaler register width: enough bits to hold DIV_N-1, never below 1.
    function automatic int presc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: raises a single-cycle clock enable every DIV_N enabled cycles.
// It produces no derived clock; tick is a qualifier in the clk domain.
module tick_gen
    import counter_pkg::*;
#(
    parameter int DIV_N = 8388608
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = presc_w(DIV_N);
    localparam logic [CW-1:0] LAST = CW'(DIV_N - 1);

    logic [CW-1:0] cnt;

    // Tick only while running; it is held off when en is low.
    assign tick = en && (cnt == LAST);

    // Phase counter: cleared by clr, frozen while disabled, wraps at LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap, saturate and one-shot modes,
// advanced by a prescaled tick and loadable at any time.
module prog_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255,
    parameter int DIV_N   = 8388608
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             done
);

    // Reject impossible parameter sets while elaborating.
    if (WIDTH < 1) begin : g_bad_width
        $error("prog_counter: WIDTH must be >= 1");
    end
    if (MAX_VAL < 0 || (WIDTH < 31 && MAX_VAL >= (1 << WIDTH))) begin : g_bad_max
        $error("prog_counter: MAX_VAL must lie in 0..2^WIDTH-1");
    end
    if (DIV_N < 1) begin : g_bad_div
        $error("prog_counter: DIV_N must be >= 1");
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    logic             tick;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] load_clamp;
    logic             at_term;
    logic             oneshot;
    logic             frozen;

    // A load restarts the prescaler phase so the next step is a full period away.
    tick_gen #(.DIV_N(DIV_N)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    assign term       = dir ? MAXV : '0;
    assign at_term    = (out == term);
    assign load_clamp = (load_val > MAXV) ? MAXV : load_val;
    assign oneshot    = (mode == ONESHOT);
    assign frozen     = oneshot && done;

    // Count state: load wins over tick; a finished one-shot ignores ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out  <= '0;
            tc   <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            out  <= load_clamp;
            tc   <= 1'b0;
            done <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (!oneshot)
                done <= 1'b0;
            if (tick && !frozen) begin
                if (at_term) begin
                    tc <= 1'b1;
                    if (oneshot)
                        done <= 1'b1;
                    else if (mode != SAT)
                        out <= dir ? '0 : MAXV;
                end else begin
                    out <= dir ? out + WIDTH'(1) : out - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter (WIDTH=4, MAX_VAL=9, DIV_N=3):
// directed scenarios followed by random stimulus against a cycle model.
module tb_prog_counter;

    localparam int W  = 4;
    localparam int MX = 9;
    localparam int DN = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en, dir, load;
    logic [1:0]   mode;
    logic [W-1:0] load_val;
    logic [W-1:0] out;
    logic         tc, done;

    int checks = 0;
    int fails  = 0;

    // reference state
    int m_out, m_pre, m_tc, m_done;

    prog_counter #(.WIDTH(W), .MAX_VAL(MX), .DIV_N(DN)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .tc       (tc),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_pre = 0; m_tc = 0; m_done = 0;
    endtask

    // One clock of behaviour, derived from the counter rules directly.
    task automatic model_clk();
        bit tk;
        int term;
        if (load) begin
            m_out  = (int'(load_val) > MX) ? MX : int'(load_val);
            m_pre  = 0;
            m_tc   = 0;
            m_done = 0;
            return;
        end
        m_tc = 0;
        tk   = 0;
        if (en) begin
            tk    = (m_pre == DN - 1);
            m_pre = (m_pre + 1) % DN;
        end
        if (tk && !(mode == 2'b10 && m_done == 1)) begin
            term = dir ? MX : 0;
            if (m_out == term) begin
                m_tc = 1;
                if (mode == 2'b10)      m_done = 1;
                else if (mode != 2'b01) m_out = dir ? 0 : MX;
            end else begin
                m_out = dir ? (m_out + 1) % (MX + 1) : (m_out + MX) % (MX + 1);
            end
        end
        if (mode != 2'b10 && !(tk && m_done == 1 && mode == 2'b10))
            m_done = (mode == 2'b10) ? m_done : 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_clk();
        #1;
        chk("out", 32'(out), 32'(m_out));
        chk("tc", 32'(tc), 32'(m_tc));
        chk("done", 32'(done), 32'(m_done));
    endtask

    // Reset pulsed between edges; outputs must clear before the next edge.
    task automatic async_rst();
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_tc", 32'(tc), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
    endtask

    task automatic do_load(input int v, input bit d, input logic [1:0] md);
        load = 1'b1; load_val = W'(v); dir = d; mode = md;
        step();
        load = 1'b0;
    endtask

    initial begin
        int tcs;
        en = 1'b0; dir = 1'b1; mode = 2'b00; load = 1'b0; load_val = '0;
        model_reset();

        // reset state without any clock edge
        #1 rst = 1'b1;
        #1;
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_tc", 32'(tc), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // wrap up-count: tc once per wrap
        en = 1'b1; dir = 1'b1; mode = 2'b00; tcs = 0;
        repeat (33) begin step(); if (tc) tcs++; end
        chk("wrap_tc_count", tcs, 1);
        chk("wrap_out", 32'(out), 32'd1);

        // saturate down from 2
        do_load(2, 1'b0, 2'b01);
        chk("sat_load", 32'(out), 32'd2);
        tcs = 0;
        repeat (15) begin step(); if (tc) tcs++; end
        chk("sat_tc_count", tcs, 3);
        chk("sat_out", 32'(out), 32'd0);

        // one-shot up from 7
        do_load(7, 1'b1, 2'b10);
        tcs = 0;
        repeat (18) begin step(); if (tc) tcs++; end
        chk("os_tc_count", tcs, 1);
        chk("os_done", 32'(done), 32'd1);
        chk("os_out", 32'(out), 32'd9);
        do_load(0, 1'b1, 2'b10);
        chk("os_clear", 32'(done), 32'd0);

        // clamp and load coincident with tick
        do_load(12, 1'b1, 2'b00);
        chk("clamp", 32'(out), 32'd9);
        step(); step();
        do_load(4, 1'b1, 2'b00);
        chk("load_vs_tick", 32'(out), 32'd4);
        step(); step();
        chk("no_early_step", 32'(out), 32'd4);
        step();
        chk("step_after_load", 32'(out), 32'd5);

        // async reset mid-count, then first increment DIV_N edges later
        do_load(5, 1'b1, 2'b00);
        step();
        load = 1'b1; load_val = 4'd7;
        async_rst();
        load = 1'b0;
        step(); step();
        chk("post_rst_hold", 32'(out), 32'd0);
        step();
        chk("post_rst_first", 32'(out), 32'd1);

        // en low holds state and phase
        do_load(3, 1'b1, 2'b00);
        step(); step(); step();
        chk("pre_pause", 32'(out), 32'd4);
        step();
        en = 1'b0;
        repeat (10) step();
        chk("pause_out", 32'(out), 32'd4);
        en = 1'b1;
        step();
        chk("resume_phase", 32'(out), 32'd4);
        step();
        chk("resume_out", 32'(out), 32'd5);

        // random stimulus
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(9) != 0);
            load     = ($urandom_range(15) == 0);
            load_val = W'($urandom_range(15));
            if ($urandom_range(7) == 0) dir  = 1'($urandom_range(1));
            if ($urandom_range(11) == 0) mode = 2'($urandom_range(3));
            step();
            if ($urandom_range(199) == 0) async_rst();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    // global time bound
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
